// File: rtl/alu_pkg.sv
// Shared types for the ALU request arbiter: opcode enum, opcode width and the
// registered response record.
package alu_pkg;
  localparam int ALU_OP     = 5;
  localparam int ALU_OP_MAX = 7;
  localparam int RSP_ID_W   = 3;   // wide enough for the largest NREQ (8)

  typedef enum logic [ALU_OP-1:0] {
    ADD = 5'd0, SUB = 5'd1, AND = 5'd2, OR  = 5'd3,
    XOR = 5'd4, SLL = 5'd5, SRL = 5'd6, SRA = 5'd7
  } alu_op_e;

  typedef struct packed {
    logic [RSP_ID_W-1:0] id;
    logic [31:0]         data;
    logic                zero;
    logic                lt;
    logic                err;
  } rsp_t;
endpackage

// File: rtl/alu_req_arbiter_if.sv
// Request/response bus between the issue-side requesters and the shared ALU
// arbiter; slave is the arbiter side, master the requester/consumer side.
interface alu_req_arbiter_if #(parameter int NREQ = 4) ();
  import alu_pkg::*;
  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]             i_req_valid;
  logic [NREQ-1:0][ALU_OP-1:0] i_req_op;
  logic [NREQ-1:0][31:0]       i_req_a;
  logic [NREQ-1:0][31:0]       i_req_b;
  logic [NREQ-1:0]             o_req_ready;
  logic                        o_rsp_valid;
  logic                        i_rsp_ready;
  logic [ID_W-1:0]             o_rsp_id;
  logic [31:0]                 o_rsp_data;
  logic                        o_rsp_zero;
  logic                        o_rsp_lt;
  logic                        o_rsp_err;

  modport slave (
    input  i_req_valid, i_req_op, i_req_a, i_req_b, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_zero, o_rsp_lt, o_rsp_err
  );
  modport master (
    output i_req_valid, i_req_op, i_req_a, i_req_b, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_zero, o_rsp_lt, o_rsp_err
  );
endinterface

// File: rtl/alu_req_arbiter_alu.sv
// Combinational integer ALU; undefined opcodes flag an error and yield zero.
module alu
  import alu_pkg::*;
(
  input  logic [ALU_OP-1:0] i_op,
  input  logic [31:0]       i_a,
  input  logic [31:0]       i_b,
  output logic [31:0]       o_data,
  output logic              o_zero,
  output logic              o_lt,
  output logic              o_err
);
  always_comb begin
    o_data = '0;
    o_err  = 1'b0;
    if (i_op > ALU_OP'(ALU_OP_MAX)) begin
      o_err = 1'b1;
    end else begin
      case (alu_op_e'(i_op))
        ADD:     o_data = i_a + i_b;
        SUB:     o_data = i_a - i_b;
        AND:     o_data = i_a & i_b;
        OR:      o_data = i_a | i_b;
        XOR:     o_data = i_a ^ i_b;
        SLL:     o_data = i_a << i_b[4:0];
        SRL:     o_data = i_a >> i_b[4:0];
        SRA:     o_data = 32'($signed(i_a) >>> i_b[4:0]);
        default: o_data = '0;
      endcase
    end
  end

  assign o_zero = (o_data == 32'd0);
  assign o_lt   = ($signed(i_a) < $signed(i_b));
endmodule

// File: rtl/alu_req_arbiter_rr.sv
// Round-robin picker: first requester at or above the pointer (wrapping) wins;
// nothing is granted while i_en is low.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [ID_W-1:0] i_ptr,
  input  logic            i_en,
  output logic [NREQ-1:0] o_gnt,
  output logic [ID_W-1:0] o_idx,
  output logic            o_any
);
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (i_en && !o_any && i_req[(int'(i_ptr) + i) % NREQ]) begin
        o_gnt[(int'(i_ptr) + i) % NREQ] = 1'b1;
        o_idx = ID_W'((int'(i_ptr) + i) % NREQ);
        o_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU between NREQ round-robin requesters with a single registered
// result slot. Optional ALU_ARB_STATS_EN adds per-requester saturating grant counters.
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
`ifdef ALU_ARB_STATS_EN
  output logic [NREQ-1:0][15:0] o_grant_cnt,
`endif
  alu_req_arbiter_if.slave      bus
);
  localparam int ID_W = $clog2(NREQ);

  typedef enum logic {EMPTY, FULL} slot_e;

  slot_e           r_state, w_state_nxt;
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] w_idx;
  logic [NREQ-1:0] w_gnt;
  logic            w_fire, w_can_accept;
  rsp_t            r_rsp, w_rsp;
  logic [31:0]     w_data;
  logic            w_zero, w_lt, w_err;

  // Reset is folded in so o_req_ready drops the moment reset asserts.
  assign w_can_accept = i_rst_n & ((r_state == EMPTY) | bus.i_rsp_ready);

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .i_req (bus.i_req_valid),
    .i_ptr (r_ptr),
    .i_en  (w_can_accept),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_fire)
  );

  alu u_alu (
    .i_op   (bus.i_req_op[w_idx]),
    .i_a    (bus.i_req_a[w_idx]),
    .i_b    (bus.i_req_b[w_idx]),
    .o_data (w_data),
    .o_zero (w_zero),
    .o_lt   (w_lt),
    .o_err  (w_err)
  );

  always_comb begin
    w_rsp      = '0;
    w_rsp.id   = RSP_ID_W'(w_idx);
    w_rsp.data = w_data;
    w_rsp.zero = w_zero;
    w_rsp.lt   = w_lt;
    w_rsp.err  = w_err;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_fire)                                   w_state_nxt = FULL;
    else if (r_state == FULL && bus.i_rsp_ready)  w_state_nxt = EMPTY;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= EMPTY;
      r_ptr   <= '0;
      r_rsp   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_fire) begin
        r_rsp <= w_rsp;
        r_ptr <= (w_idx == ID_W'(NREQ - 1)) ? '0 : w_idx + 1'b1;
      end
    end
  end

  logic w_unused_id;
  assign w_unused_id = ^r_rsp.id;

  assign bus.o_req_ready = w_gnt;
  assign bus.o_rsp_valid = (r_state == FULL);
  assign bus.o_rsp_id    = r_rsp.id[ID_W-1:0];
  assign bus.o_rsp_data  = r_rsp.data;
  assign bus.o_rsp_zero  = r_rsp.zero;
  assign bus.o_rsp_lt    = r_rsp.lt;
  assign bus.o_rsp_err   = r_rsp.err;

`ifdef ALU_ARB_STATS_EN
  logic [NREQ-1:0][15:0] r_grant_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_grant_cnt <= '0;
    end else begin
      for (int g = 0; g < NREQ; g++)
        if (w_gnt[g] && r_grant_cnt[g] != 16'hFFFF)
          r_grant_cnt[g] <= r_grant_cnt[g] + 16'd1;
    end
  end

  assign o_grant_cnt = r_grant_cnt;
`endif
endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed self-checking bench for alu_req_arbiter (default and ALU_ARB_STATS_EN builds).
module tb_alu_req_arbiter;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  alu_req_arbiter_if #(.NREQ(4)) bus ();
`ifdef ALU_ARB_STATS_EN
  logic [3:0][15:0] grant_cnt;
`endif

  alu_req_arbiter #(.NREQ(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
`ifdef ALU_ARB_STATS_EN
    .o_grant_cnt (grant_cnt),
`endif
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_reqs();
    bus.i_req_valid = '0;
    bus.i_req_op    = '0;
    bus.i_req_a     = '0;
    bus.i_req_b     = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_reqs();
    bus.i_rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Presents one request from requester k, lets it transfer, then withdraws it.
  task automatic issue(input int k, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.i_req_valid[k] = 1'b1;
    bus.i_req_op[k]    = op;
    bus.i_req_a[k]     = a;
    bus.i_req_b[k]     = b;
    @(posedge clk); #1;
    bus.i_req_valid[k] = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_tests++; if (bus.o_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b exp 0", bus.o_rsp_valid); end
    n_tests++; if (bus.o_rsp_id !== 2'd0) begin n_fail++; $display("FAIL rst_id: got %0d exp 0", bus.o_rsp_id); end
    n_tests++; if (bus.o_rsp_data !== 32'd0) begin n_fail++; $display("FAIL rst_data: got %0h exp 0", bus.o_rsp_data); end
    n_tests++; if ({bus.o_rsp_zero, bus.o_rsp_lt, bus.o_rsp_err} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %03b exp 000", {bus.o_rsp_zero, bus.o_rsp_lt, bus.o_rsp_err}); end
    n_tests++; if (bus.o_req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_ready_idle: got %04b exp 0000", bus.o_req_ready); end
    // Fill the slot under backpressure, then reset asynchronously mid-cycle.
    bus.i_rsp_ready = 1'b0;
    issue(0, 5'd0, 32'd1, 32'd2);
    bus.i_req_valid[0] = 1'b1;
    #2;
    n_tests++; if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_data !== 32'd3) begin n_fail++; $display("FAIL pre_rst_rsp: got v=%0b d=%0h exp v=1 d=3", bus.o_rsp_valid, bus.o_rsp_data); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (bus.o_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %0b exp 0", bus.o_rsp_valid); end
    n_tests++; if (bus.o_rsp_data !== 32'd0) begin n_fail++; $display("FAIL midrst_data: got %0h exp 0", bus.o_rsp_data); end
    n_tests++; if (bus.o_req_ready !== 4'b0000) begin n_fail++; $display("FAIL midrst_ready: got %04b exp 0000", bus.o_req_ready); end
    @(negedge clk);
    clear_reqs();
    bus.i_rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_tests++; if (bus.o_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_stale c%0d: got %0b exp 0", c, bus.o_rsp_valid); end
    end
  endtask

  task automatic test_single();
    apply_reset();
    @(negedge clk);
    bus.i_req_valid[2] = 1'b1;
    bus.i_req_op[2]    = 5'd0;
    bus.i_req_a[2]     = 32'd5;
    bus.i_req_b[2]     = 32'd7;
    #1;
    n_tests++; if (bus.o_req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %04b exp 0100", bus.o_req_ready); end
    @(posedge clk); #1;
    bus.i_req_valid[2] = 1'b0;
    n_tests++; if (bus.o_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0b exp 1", bus.o_rsp_valid); end
    n_tests++; if (bus.o_rsp_id !== 2'd2) begin n_fail++; $display("FAIL single_id: got %0d exp 2", bus.o_rsp_id); end
    n_tests++; if (bus.o_rsp_data !== 32'd12) begin n_fail++; $display("FAIL single_data: got %0d exp 12", bus.o_rsp_data); end
    n_tests++; if ({bus.o_rsp_zero, bus.o_rsp_lt, bus.o_rsp_err} !== 3'b010) begin n_fail++; $display("FAIL single_flags: got %03b exp 010", {bus.o_rsp_zero, bus.o_rsp_lt, bus.o_rsp_err}); end
    @(posedge clk); #1;
    n_tests++; if (bus.o_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %0b exp 0", bus.o_rsp_valid); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    int         exp_id;
    apply_reset();
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      bus.i_req_valid[k] = 1'b1;
      bus.i_req_op[k]    = 5'd0;
      bus.i_req_a[k]     = 32'(k * 10);
      bus.i_req_b[k]     = 32'd1;
    end
    #1;
    for (int c = 0; c < 5; c++) begin
      exp_id  = c % 4;
      exp_rdy = 4'b0001 << exp_id;
      n_tests++; if (bus.o_req_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_ready c%0d: got %04b exp %04b", c, bus.o_req_ready, exp_rdy); end
      @(posedge clk); #1;
      n_tests++; if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_id !== 2'(exp_id) || bus.o_rsp_data !== 32'(exp_id * 10 + 1))
        begin n_fail++; $display("FAIL rr_rsp c%0d: got v=%0b id=%0d d=%0d exp v=1 id=%0d d=%0d", c, bus.o_rsp_valid, bus.o_rsp_id, bus.o_rsp_data, exp_id, exp_id * 10 + 1); end
    end
    clear_reqs();
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    // Pointer sits at 1 after the round-robin run.
    bus.i_rsp_ready = 1'b0;
    issue(1, 5'd1, 32'd20, 32'd3);
    n_tests++; if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_id !== 2'd1 || bus.o_rsp_data !== 32'd17)
      begin n_fail++; $display("FAIL bp_first: got v=%0b id=%0d d=%0d exp v=1 id=1 d=17", bus.o_rsp_valid, bus.o_rsp_id, bus.o_rsp_data); end
    bus.i_req_valid[3] = 1'b1;
    bus.i_req_op[3]    = 5'd4;
    bus.i_req_a[3]     = 32'hF0;
    bus.i_req_b[3]     = 32'h0F;
    #1;
    n_tests++; if (bus.o_req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready_blocked: got %04b exp 0000", bus.o_req_ready); end
    @(posedge clk); #1;
    n_tests++; if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_id !== 2'd1 || bus.o_rsp_data !== 32'd17 || bus.o_rsp_lt !== 1'b0)
      begin n_fail++; $display("FAIL bp_hold: got v=%0b id=%0d d=%0d lt=%0b exp v=1 id=1 d=17 lt=0", bus.o_rsp_valid, bus.o_rsp_id, bus.o_rsp_data, bus.o_rsp_lt); end
    bus.i_rsp_ready = 1'b1;
    #1;
    n_tests++; if (bus.o_req_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_release_ready: got %04b exp 1000", bus.o_req_ready); end
    @(posedge clk); #1;
    bus.i_req_valid[3] = 1'b0;
    n_tests++; if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_id !== 2'd3 || bus.o_rsp_data !== 32'hFF)
      begin n_fail++; $display("FAIL bp_replace: got v=%0b id=%0d d=%0h exp v=1 id=3 d=ff", bus.o_rsp_valid, bus.o_rsp_id, bus.o_rsp_data); end
    @(posedge clk); #1;
    n_tests++; if (bus.o_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %0b exp 0", bus.o_rsp_valid); end
  endtask

  task automatic test_alu_edges();
    issue(0, 5'd7, 32'h8000_0000, 32'd4);
    n_tests++; if (bus.o_rsp_data !== 32'hF800_0000 || bus.o_rsp_lt !== 1'b1 || bus.o_rsp_err !== 1'b0)
      begin n_fail++; $display("FAIL alu_sra: got d=%0h lt=%0b err=%0b exp d=f8000000 lt=1 err=0", bus.o_rsp_data, bus.o_rsp_lt, bus.o_rsp_err); end
    issue(0, 5'd1, 32'd9, 32'd9);
    n_tests++; if (bus.o_rsp_data !== 32'd0 || bus.o_rsp_zero !== 1'b1 || bus.o_rsp_lt !== 1'b0)
      begin n_fail++; $display("FAIL alu_sub_zero: got d=%0h z=%0b lt=%0b exp d=0 z=1 lt=0", bus.o_rsp_data, bus.o_rsp_zero, bus.o_rsp_lt); end
    issue(0, 5'd9, 32'h1234, 32'h5678);
    n_tests++; if (bus.o_rsp_err !== 1'b1 || bus.o_rsp_data !== 32'd0)
      begin n_fail++; $display("FAIL alu_bad_op: got err=%0b d=%0h exp err=1 d=0", bus.o_rsp_err, bus.o_rsp_data); end
    issue(2, 5'd5, 32'd1, 32'd31);
    n_tests++; if (bus.o_rsp_data !== 32'h8000_0000 || bus.o_rsp_zero !== 1'b0 || bus.o_rsp_id !== 2'd2)
      begin n_fail++; $display("FAIL alu_sll: got d=%0h z=%0b id=%0d exp d=80000000 z=0 id=2", bus.o_rsp_data, bus.o_rsp_zero, bus.o_rsp_id); end
    issue(1, 5'd6, 32'h8000_0000, 32'd31);
    n_tests++; if (bus.o_rsp_data !== 32'd1 || bus.o_rsp_lt !== 1'b1)
      begin n_fail++; $display("FAIL alu_srl: got d=%0h lt=%0b exp d=1 lt=1", bus.o_rsp_data, bus.o_rsp_lt); end
    issue(3, 5'd2, 32'hFF00_FF00, 32'h0FF0_0FF0);
    n_tests++; if (bus.o_rsp_data !== 32'h0F00_0F00) begin n_fail++; $display("FAIL alu_and: got %0h exp f000f00", bus.o_rsp_data); end
    issue(0, 5'd3, 32'hFF00_0000, 32'h0000_00FF);
    n_tests++; if (bus.o_rsp_data !== 32'hFF00_00FF) begin n_fail++; $display("FAIL alu_or: got %0h exp ff0000ff", bus.o_rsp_data); end
    @(posedge clk); #1;
  endtask

`ifdef ALU_ARB_STATS_EN
  task automatic test_stats();
    apply_reset();
    #1;
    n_tests++; if (grant_cnt !== '0) begin n_fail++; $display("FAIL stats_reset: got %0h exp 0", grant_cnt); end
    @(negedge clk);
    bus.i_req_valid[1] = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    bus.i_req_valid[1] = 1'b0;
    n_tests++; if (grant_cnt[1] !== 16'hFFFF) begin n_fail++; $display("FAIL stats_sat: got %0h exp ffff", grant_cnt[1]); end
    n_tests++; if (grant_cnt[0] !== 16'd0 || grant_cnt[2] !== 16'd0 || grant_cnt[3] !== 16'd0)
      begin n_fail++; $display("FAIL stats_others: got %0h %0h %0h exp 0 0 0", grant_cnt[0], grant_cnt[2], grant_cnt[3]); end
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.i_rsp_ready = 1'b1;
    clear_reqs();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_alu_edges();
`ifdef ALU_ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
